vrf_read_sequencer: RTL

Upstream feeder for the VRF read pipe. It accepts one read command per vector instruction: start register, start offset, read count, source and instruction index. It expands the command into a stream of single-word read requests on the read pipe's enqueue port. It limits outstanding reads to the read pipe's data-queue depth and pulses `done` once every requested word has been dequeued downstream.

---
 rtl/vrf_read_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/vrf_read_sequencer.sv
// Purpose: expands one VRF read command into single-word read requests and
//   limits outstanding reads to the read-pipe data-queue depth.
// Latency: first request one cycle after command accept; done one cycle after the last return.
// Backpressure: req_bits hold while req_ready is low; issue stalls at MAX_OUTSTANDING.
// Ports:
//   clock/reset       - single clock, synchronous active-high reset
//   cmd_*             - command handshake (cmd_ready only in IDLE)
//   req_*             - read request stream into the read-pipe enqueue port
//   resp_fire         - read-pipe dequeue handshake (returns one credit)
//   busy/done/err     - status: not idle, completion pulse, sticky stray-return flag
module vrf_read_sequencer #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int COUNT_WIDTH     = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   cmd_ready,
  input  logic                   cmd_valid,
  input  logic [4:0]             cmd_bits_vs,
  input  logic [8:0]             cmd_bits_offset,
  input  logic [COUNT_WIDTH-1:0] cmd_bits_count,
  input  logic [3:0]             cmd_bits_readSource,
  input  logic [2:0]             cmd_bits_instructionIndex,
  input  logic                   req_ready,
  output logic                   req_valid,
  output logic [4:0]             req_bits_vs,
  output logic [8:0]             req_bits_offset,
  output logic [3:0]             req_bits_groupIndex,
  output logic [3:0]             req_bits_readSource,
  output logic [2:0]             req_bits_instructionIndex,
  input  logic                   resp_fire,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [OW-1:0]          outstanding;
  logic [4:0]             cur_vs;
  logic [8:0]             cur_offset;
  logic [3:0]             grp;
  logic [3:0]             read_source;
  logic [2:0]             instr_index;
  logic                   done_q;
  logic                   err_q;

  logic cmd_fire, req_fire, last_fire, resp_ok, drain_exit;

  assign cmd_fire   = cmd_valid & cmd_ready;
  assign req_fire   = req_valid & req_ready;
  assign last_fire  = req_fire & (remaining == COUNT_WIDTH'(1));
  // A return only counts against a real outstanding read; otherwise it is stray.
  assign resp_ok    = resp_fire & (outstanding != '0);
  assign drain_exit = (state == DRAIN) &
                      ((outstanding == '0) | ((outstanding == OW'(1)) & resp_fire));

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire && cmd_bits_count != '0) state_nxt = ISSUE;
      ISSUE:   if (last_fire) state_nxt = DRAIN;
      DRAIN:   if (drain_exit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: req_valid looks only at registered state and credit count so there
  // is no combinational path from req_ready or resp_fire.
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    req_valid = (state == ISSUE) && (outstanding < MAX_OUT);
  end

  assign req_bits_vs               = cur_vs;
  assign req_bits_offset           = cur_offset;
  assign req_bits_groupIndex       = grp;
  assign req_bits_readSource       = read_source;
  assign req_bits_instructionIndex = instr_index;
  assign done                      = done_q;
  assign err                       = err_q;

  // Datapath, credit counter and status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      remaining   <= '0;
      outstanding <= '0;
      cur_vs      <= '0;
      cur_offset  <= '0;
      grp         <= '0;
      read_source <= '0;
      instr_index <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (cmd_fire) begin
        cur_vs      <= cmd_bits_vs;
        cur_offset  <= cmd_bits_offset;
        remaining   <= cmd_bits_count;
        read_source <= cmd_bits_readSource;
        instr_index <= cmd_bits_instructionIndex;
        grp         <= '0;
      end else if (req_fire) begin
        remaining  <= remaining - COUNT_WIDTH'(1);
        grp        <= grp + 4'd1;
        // Offset rolls over into the next register; v31 rolls over to v0.
        cur_offset <= cur_offset + 9'd1;
        if (cur_offset == 9'd511) cur_vs <= cur_vs + 5'd1;
      end

      case ({req_fire, resp_ok})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase

      if (resp_fire && outstanding == '0) err_q <= 1'b1;

      // Zero-count commands complete straight from IDLE.
      done_q <= (cmd_fire & (cmd_bits_count == '0)) | drain_exit;
    end
  end

endmodule
